hub75_pixel_loader: RTL
=======================

HUB75_PIXEL_LOADER -- requirements
Module: hub75_pixel_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, 4..64): pixel-word buffer depth.
REQ-002 SHALL have parameter ADDR_W, default 15: panel-memory word-address width.
REQ-003 SHALL have parameter DATA_W, default 32: pixel-word width.
REQ-004 SHALL have port PCLK  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port PRESETN  in  1  asynchronous active-low reset.
REQ-006 SHALL have port px_valid  in  1  upstream pixel word present.
REQ-007 SHALL have port px_data  in  DATA_W  upstream pixel word.
REQ-008 SHALL have port px_ready  out  1  loader can accept a word this cycle.
REQ-009 SHALL have port addr_load  in  1  one-cycle pulse; load write pointer.
REQ-010 SHALL have port addr_base  in  ADDR_W  value loaded by addr_load.
REQ-011 SHALL have port frame_words  in  ADDR_W  frame size in words; pointer wrap limit.
REQ-012 SHALL have port sync_mode  in  1  1 = drain only after frame_sync rising edge.
REQ-013 SHALL have port frame_sync  in  1  frame marker from panel timing stage.
REQ-014 SHALL have port flush  in  1  one-cycle pulse; discard buffered words.
REQ-015 SHALL have port mem_wr  out  1  panel-memory write strobe.
REQ-016 SHALL have port mem_waddr  out  ADDR_W  panel-memory write address.
REQ-017 SHALL have port mem_data  out  DATA_W  panel-memory write data.
REQ-018 SHALL have port fifo_level  out  clog2(FIFO_DEPTH)+1  buffered word count.

Function
REQ-019 SHALL drive px_ready = (fifo_level < FIFO_DEPTH); a word is accepted when px_valid && px_ready.
REQ-020 SHALL, when full, hold px_ready low and leave px_valid/px_data unsampled; no word lost or overwritten.
REQ-021 SHALL have states IDLE, DRAIN, WAIT_SYNC; IDLE after reset.
REQ-022 SHALL transition IDLE->DRAIN when FIFO non-empty and sync_mode=0; IDLE->WAIT_SYNC when FIFO non-empty and sync_mode=1.
REQ-023 SHALL transition WAIT_SYNC->DRAIN on a detected frame_sync rising edge (registered previous value; edge visible one cycle after it occurs).
REQ-024 SHALL, in DRAIN, pop one word per cycle and emit registered mem_wr=1, mem_data=word, mem_waddr=pointer in the cycle after the pop.
REQ-025 SHALL transition DRAIN->IDLE when the FIFO becomes empty; a word pushed in the same cycle as the last pop keeps the state in DRAIN.
REQ-026 SHALL have minimum latency, sync_mode=0, two cycles from accepting handshake edge to mem_wr high.
REQ-027 SHALL post-increment the pointer after each write; when the pointer equals frame_words-1 the next value SHALL be 0; frame_words=0 treated as 2^ADDR_W.
REQ-028 SHALL, on addr_load, set the pointer to addr_base; a write issued that same cycle uses the old pointer; the next write uses addr_base.
REQ-029 SHALL, on flush, empty the FIFO, return to IDLE and suppress the pending pop; an in-flight registered write already presented completes; pointer unchanged; a push in the flush cycle is discarded.
REQ-030 SHALL accept simultaneous push and pop with fifo_level unchanged.
REQ-031 SHALL drive mem_wr low in every cycle not carrying a write; mem_data/mem_waddr hold last value.
REQ-032 SHALL sample sync_mode only in IDLE; changes during DRAIN/WAIT_SYNC take effect at the next IDLE exit.

Reset
REQ-033 SHALL, while PRESETN=0, force state IDLE, pointer 0, FIFO empty, fifo_level 0, mem_wr 0, mem_waddr 0, mem_data 0, px_ready 0, frame_sync edge register 0.
REQ-034 SHALL assert px_ready in the first cycle after PRESETN deasserts.
REQ-035 SHALL, on reset mid-DRAIN, discard all buffered words with no partial write emitted.

Structure
REQ-036 SHALL take ADDR_W/DATA_W defaults and the state enumeration from shared package hub75_pkg.
REQ-037 SHALL implement buffering in sub-module hub75_sync_fifo (push/pop/flush/level, no fall-through).

Verification
REQ-038 SHALL verify: sync_mode=0, addr_load base 0x0100, push 0xAABBCCDD -> mem_wr one cycle at addr 0x0100 data 0xAABBCCDD, 2 cycles after handshake.
REQ-039 SHALL verify: push 9 words back-to-back with sync_mode=1, no frame_sync -> px_ready low after 8, fifo_level=8, no mem_wr; then frame_sync pulse -> 8 consecutive writes, then the 9th.
REQ-040 SHALL verify: frame_words=4, base 2, push 4 words -> addresses 2,3,0,1.
REQ-041 SHALL verify: addr_load base 0x0010 in same cycle as a write at 0x0005 -> that write at 0x0005, next at 0x0010.
REQ-042 SHALL verify: flush with 5 words buffered -> fifo_level 0 next cycle, at most 1 further mem_wr, pointer unchanged.
REQ-043 SHALL verify: PRESETN low mid-drain with 3 words buffered -> mem_wr 0 immediately, all outputs at reset values, px_ready 1 one cycle after release.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel pixel path.
// Default bus widths and the loader state encoding.
package hub75_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN     = 2'd1,
        WAIT_SYNC = 2'd2
    } loader_state_t;

endpackage

// File: rtl/hub75_sync_fifo.sv
// Synchronous pixel-word FIFO with flush and occupancy level.
// Read data is the stored head word; a push is visible the cycle after.
module hub75_sync_fifo
    import hub75_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LW-1:0]     level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hub75_pixel_loader.sv
// Buffers upstream pixel words and writes them into panel memory
// at a wrapping address pointer, optionally gated on frame sync.
module hub75_pixel_loader
    import hub75_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              px_valid,
    input  logic [DATA_W-1:0] px_data,
    output logic              px_ready,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic [ADDR_W-1:0] frame_words,
    input  logic              sync_mode,
    input  logic              frame_sync,
    input  logic              flush,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_data,
    output logic [LVL_W-1:0]  fifo_level
);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [DATA_W-1:0] rd_data;
    logic              rst_done;
    logic              sync_q;
    logic              sync_rise;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              empty;
    logic              full;

    // Held low through reset so no word is accepted before the FIFO is clean.
    assign px_ready  = rst_done && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push      = px_valid && px_ready;
    assign sync_rise = frame_sync && !sync_q;
    assign pop       = (state == DRAIN) && !empty && !flush;
    assign last_pop  = pop && !push && (fifo_level == LVL_W'(1));

    // frame_words of zero makes the limit all-ones, i.e. a full 2^ADDR_W wrap.
    assign ptr_inc = (ptr == frame_words - 1'b1) ? '0 : ptr + 1'b1;

    hub75_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (px_data),
        .rdata (rd_data),
        .level (fifo_level),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (!empty)
                    state_nxt = sync_mode ? WAIT_SYNC : DRAIN;
            WAIT_SYNC:
                if (sync_rise)
                    state_nxt = DRAIN;
            DRAIN:
                if (last_pop)
                    state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= IDLE;
            rst_done  <= 1'b0;
            sync_q    <= 1'b0;
            ptr       <= '0;
            mem_wr    <= 1'b0;
            mem_waddr <= '0;
            mem_data  <= '0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            sync_q   <= frame_sync;
            mem_wr   <= pop;
            if (pop) begin
                mem_waddr <= ptr;
                mem_data  <= rd_data;
            end
            if (addr_load)
                ptr <= addr_base;
            else if (pop)
                ptr <= ptr_inc;
        end
    end

endmodule
